// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 frame receiver feeding a show-ahead scan-code FIFO
// Ports: clk system clock; rst async active-low reset; ps2_clk/ps2_data raw PS/2 lines;
//        rd_en pop request; data head entry; valid FIFO non-empty;
//        overflow sticky drop flag; frame_err one-cycle malformed/timed-out frame pulse
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic {IDLE, RECV} state_t;
    state_t        st;
    logic          c1, c2, c3, d1, d2;
    logic [3:0]    cnt;
    logic [TW-1:0] tcnt;
    logic [9:0]    sh;
    logic          wr;
    logic [7:0]    wdat;
    logic [AW:0]   wp, rp;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          fall, good, full, pop, push;
    // sh holds start..parity with start ending up in sh[0]; the stop bit is still in d2
    assign fall  = !c2 && c3;
    assign good  = !sh[0] && d2 && ^sh[9:1];
    assign valid = wp != rp;
    assign full  = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign pop   = rd_en && valid;
    assign push  = wr && (!full || pop);
    assign data  = mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            sh        <= '0;
            {c1, c2, c3, d1, d2} <= '1;
            wr        <= 1'b0;
            wdat      <= '0;
            frame_err <= 1'b0;
        end else begin
            {c1, c2, c3} <= {ps2_clk, c1, c2};
            {d1, d2}     <= {ps2_data, d1};
            wr        <= 1'b0;
            frame_err <= 1'b0;
            if (st == IDLE) begin
                tcnt <= '0;
                if (fall && !d2) begin
                    sh  <= {d2, sh[9:1]};
                    cnt <= 4'd1;
                    st  <= RECV;
                end
            end else if (fall) begin
                tcnt <= '0;
                if (cnt == 4'd10) begin
                    wr        <= good;
                    wdat      <= sh[8:1];
                    frame_err <= !good;
                    cnt       <= '0;
                    st        <= IDLE;
                end else begin
                    sh  <= {d2, sh[9:1]};
                    cnt <= cnt + 4'd1;
                end
            end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                tcnt      <= '0;
                cnt       <= '0;
                frame_err <= 1'b1;
                st        <= IDLE;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (wr && full && !pop) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= wdat;
    end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, the number of scan-code entries; it shall be a power of two, 2..64.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 20000, the number of clk cycles without a ps2_clk falling edge after which a partial frame is abandoned.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ps2_clk, input, 1 bit: the PS/2 device clock, asynchronous to clk.
REQ-006 The block SHALL have port ps2_data, input, 1 bit: the PS/2 device data, asynchronous to clk.
REQ-007 The block SHALL have port rd_en, input, 1 bit: pop request from the consumer.
REQ-008 The block SHALL have port data, output, 8 bits: the scan code at the FIFO head (show-ahead).
REQ-009 The block SHALL have port valid, output, 1 bit: high when the FIFO is non-empty.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a good frame is dropped because the FIFO is full.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a received frame is malformed.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer, plus one history flop on ps2_clk.
REQ-013 A falling edge SHALL be detected when the synchronized ps2_clk is 0 and its history flop is 1; ps2_data SHALL be sampled in that same cycle.
REQ-014 Receiver states SHALL be IDLE and RECV; a bit counter 0..10 SHALL count the bits sampled.
REQ-015 In IDLE, a falling edge with sampled data 0 SHALL load the start bit and enter RECV with the counter at 1; a falling edge with data 1 SHALL be ignored.
REQ-016 In RECV, each falling edge SHALL shift in one bit: bits 1-8 are data LSB first, bit 9 is parity, bit 10 is stop.
REQ-017 On the edge that samples bit 10, the frame SHALL be good iff start=0, stop=1 and the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
REQ-018 A good frame SHALL be written to the FIFO on the next clk edge; a bad frame SHALL be discarded and SHALL pulse frame_err for exactly 1 cycle.
REQ-019 After bit 10 the receiver SHALL return to IDLE.
REQ-020 In RECV, a timeout counter SHALL reset on every falling edge; on reaching TIMEOUT_CYC it SHALL return the receiver to IDLE, discard the partial frame and pulse frame_err.
REQ-021 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-022 The FIFO SHALL be empty when the pointers are equal, and full when they differ only in the MSB.
REQ-023 data SHALL equal the entry at the read pointer combinationally; data is don't-care while valid=0.
REQ-024 rd_en with valid=1 SHALL advance the read pointer on the next edge; rd_en with valid=0 SHALL be ignored.
REQ-025 A good frame arriving when full SHALL be written only if a pop occurs in the same cycle; otherwise it SHALL be dropped and overflow set.
REQ-026 A simultaneous write and pop when not full SHALL both take effect, leaving occupancy unchanged.
REQ-027 overflow SHALL stay high until reset.
REQ-028 Latency from the stop-bit ps2_clk falling at the pin to valid rising on an empty FIFO SHALL be 3 to 4 clk cycles.

Reset
REQ-029 While rst=0, the block SHALL force: receiver IDLE, bit and timeout counters 0, pointers 0, valid=0, overflow=0, frame_err=0, synchronizer flops 1.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL decode correctly.
REQ-031 FIFO storage contents SHALL NOT need reset.

Verification
REQ-032 Single frame: frame 0x1C with parity 0, stop 1 -> valid=1 within 4 cycles of the stop edge, data=0x1C; rd_en for 1 cycle -> valid=0.
REQ-033 Sequence: frames F0, 1C (no reads) -> data=0xF0 first; after one pop data=0x1C; after a second pop valid=0.
REQ-034 Parity error: frame 0x1C with parity 1 -> frame_err pulses 1 cycle, valid stays 0.
REQ-035 Overflow: 9 good frames (0x01..0x09), no reads, depth 8 -> overflow=1; 8 pops return 0x01..0x08, then valid=0.
REQ-036 Timeout: 4 bits then ps2_clk held high for 20000 cycles -> frame_err pulse, receiver IDLE; a following frame 0x5A -> data=0x5A.
REQ-037 Full plus pop: FIFO full while a good frame 0x33 completes in the same cycle as rd_en=1 -> no overflow, 0x33 is the 8th entry.
